// File: rtl/VX_gpu_pkg.sv
// Shared definitions for the dispatch batch scheduler: state encoding and
// helpers deriving the batch count and batch index width from the lane layout.
package VX_gpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    function automatic int batch_count(input int issue_width, input int block_size);
        return issue_width / block_size;
    endfunction

    // A single batch still needs a 1-bit index so the port is never zero width.
    function automatic int batch_count_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/dispatch_batch_sched_rr_pick.sv
// Combinational round-robin pick: the first requesting batch at or after ptr,
// wrapping, optionally with one batch masked out.
module dispatch_batch_rr_pick
    import VX_gpu_pkg::*;
#(
    parameter int BATCH_COUNT   = 4,
    parameter int BATCH_COUNT_W = 2
) (
    input  logic [BATCH_COUNT-1:0]   req,
    input  logic [BATCH_COUNT_W-1:0] ptr,
    input  logic                     exclude_en,
    input  logic [BATCH_COUNT_W-1:0] exclude_idx,
    output logic [BATCH_COUNT_W-1:0] grant_idx,
    output logic                     grant_valid
);

    logic [BATCH_COUNT-1:0] masked;

    always_comb begin
        masked = req;
        if (exclude_en) begin
            masked[exclude_idx] = 1'b0;
        end
    end

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        int cand;
        cand        = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = BATCH_COUNT - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % BATCH_COUNT;
            if (masked[cand]) begin
                grant_idx   = BATCH_COUNT_W'(cand);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_batch_sched.sv
// Dispatch batch scheduler: locks one batch of issue slots onto the block lanes
// until every lane has finished, then advances round-robin to the next batch.
module dispatch_batch_sched
    import VX_gpu_pkg::*;
#(
    parameter int ISSUE_WIDTH   = 4,
    parameter int BLOCK_SIZE    = 1,
    parameter int PERF_CTR_BITS = 44,
    localparam int BATCH_COUNT   = batch_count(ISSUE_WIDTH, BLOCK_SIZE),
    localparam int BATCH_COUNT_W = batch_count_w(BATCH_COUNT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ISSUE_WIDTH-1:0]   dispatch_valid,
    input  logic [BLOCK_SIZE-1:0]    block_fire_eop,
    output logic [BATCH_COUNT_W-1:0] batch_idx,
    output logic                     batch_active,
    output logic [BLOCK_SIZE-1:0]    block_enable,
    output logic                     batch_done,
    output logic [PERF_CTR_BITS-1:0] perf_switches,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);

    // Lane protocol: lane b presents packets only while block_enable[b] is high;
    // block_fire_eop[b] marks its last packet and is ignored while disabled.
    // A lane is finished once its EOP fired or its slot in the batch is invalid.

    sched_state_e state_q, state_d;
    logic [BATCH_COUNT_W-1:0] batch_idx_q, batch_idx_d;
    logic [BATCH_COUNT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BLOCK_SIZE-1:0]    done_mask_q, done_mask_d;
    logic [PERF_CTR_BITS-1:0] switches_q, switches_d;
    logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;

    logic [BATCH_COUNT-1:0]   batch_req;
    logic [BLOCK_SIZE-1:0]    cur_valid;
    logic [BLOCK_SIZE-1:0]    grant_slot_valid;
    logic [BLOCK_SIZE-1:0]    done_now;
    logic [BATCH_COUNT_W-1:0] rr_next;
    logic [BATCH_COUNT_W-1:0] pick_ptr;
    logic [BATCH_COUNT_W-1:0] grant_idx;
    logic                     grant_valid;
    logic                     locked;

    always_comb begin
        batch_req = '0;
        for (int i = 0; i < BATCH_COUNT; i++) begin
            batch_req[i] = |dispatch_valid[i*BLOCK_SIZE +: BLOCK_SIZE];
        end
    end

    assign locked           = (state_q == LOCKED);
    assign cur_valid        = dispatch_valid[batch_idx_q*BLOCK_SIZE +: BLOCK_SIZE];
    assign grant_slot_valid = dispatch_valid[grant_idx*BLOCK_SIZE +: BLOCK_SIZE];
    assign done_now         = block_fire_eop | ~cur_valid;
    assign rr_next          = (int'(batch_idx_q) == BATCH_COUNT - 1) ? '0
                                                                     : batch_idx_q + 1'b1;

    // While locked the pick only matters on completion, where it searches past
    // the current batch with that batch excluded.
    assign pick_ptr = locked ? rr_next : rr_ptr_q;

    dispatch_batch_rr_pick #(
        .BATCH_COUNT   (BATCH_COUNT),
        .BATCH_COUNT_W (BATCH_COUNT_W)
    ) u_rr_pick (
        .req         (batch_req),
        .ptr         (pick_ptr),
        .exclude_en  (locked),
        .exclude_idx (batch_idx_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d     = state_q;
        batch_idx_d = batch_idx_q;
        rr_ptr_d    = rr_ptr_q;
        done_mask_d = done_mask_q;
        switches_d  = switches_q;
        stalls_d    = stalls_q;
        batch_done  = 1'b0;

        if (!locked && (|dispatch_valid)) begin
            stalls_d = stalls_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d     = LOCKED;
                    batch_idx_d = grant_idx;
                    // Lanes whose slot is empty in the new batch start out done.
                    done_mask_d = ~grant_slot_valid;
                end
            end
            LOCKED: begin
                done_mask_d = done_mask_q | done_now;
                if (&(done_mask_q | done_now)) begin
                    batch_done = 1'b1;
                    rr_ptr_d   = rr_next;
                    switches_d = switches_q + 1'b1;
                    if (grant_valid) begin
                        batch_idx_d = grant_idx;
                        done_mask_d = ~grant_slot_valid;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (BATCH_COUNT == 1) begin
            batch_idx_d = '0;
            rr_ptr_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            batch_idx_q <= '0;
            rr_ptr_q    <= '0;
            done_mask_q <= '0;
            switches_q  <= '0;
            stalls_q    <= '0;
        end else begin
            state_q     <= state_d;
            batch_idx_q <= batch_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            done_mask_q <= done_mask_d;
            switches_q  <= switches_d;
            stalls_q    <= stalls_d;
        end
    end

    assign batch_idx     = batch_idx_q;
    assign batch_active  = locked;
    assign block_enable  = locked ? ~done_mask_q : '0;
    assign perf_switches = switches_q;
    assign perf_stalls   = stalls_q;

endmodule

// File: tb/tb_dispatch_batch_sched.sv
// Scoreboard bench: two scheduler configurations (2 batches of 2 lanes, and a
// single batch of 4 lanes) checked every cycle against a behavioural model.
module tb_dispatch_batch_sched;

    localparam int EW = 95;  // {idx, active, enable[3:0], done, switches[43:0], stalls[43:0]}

    logic        clk;
    logic        reset;
    logic [3:0]  dv_a, dv_b;
    logic [1:0]  eop_a;
    logic [3:0]  eop_b;
    logic [0:0]  idx_a, idx_b;
    logic        act_a, act_b;
    logic [1:0]  en_a;
    logic [3:0]  en_b;
    logic        done_a, done_b;
    logic [43:0] sw_a, sw_b, st_a, st_b;

    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    int n_checks;
    int n_errors;

    // model state, index 0 = config A, index 1 = config B
    logic        m_active [2];
    int          m_cur    [2];
    int          m_rr     [2];
    logic [3:0]  m_done   [2];
    logic [43:0] m_sw     [2];
    logic [43:0] m_st     [2];

    dispatch_batch_sched #(.ISSUE_WIDTH(4), .BLOCK_SIZE(2), .PERF_CTR_BITS(44)) dut_a (
        .clk(clk), .reset(reset), .dispatch_valid(dv_a), .block_fire_eop(eop_a),
        .batch_idx(idx_a), .batch_active(act_a), .block_enable(en_a),
        .batch_done(done_a), .perf_switches(sw_a), .perf_stalls(st_a)
    );

    dispatch_batch_sched #(.ISSUE_WIDTH(4), .BLOCK_SIZE(4), .PERF_CTR_BITS(44)) dut_b (
        .clk(clk), .reset(reset), .dispatch_valid(dv_b), .block_fire_eop(eop_b),
        .batch_idx(idx_b), .batch_active(act_b), .block_enable(en_b),
        .batch_done(done_b), .perf_switches(sw_b), .perf_stalls(st_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic batch_has_req(input int bs, input logic [3:0] dv, input int i);
        for (int b = 0; b < bs; b++) begin
            if (dv[i*bs + b]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int find_req(input int bs, input logic [3:0] dv, input int start,
                                    input int excl);
        int bc;
        int i;
        bc = 4 / bs;
        for (int k = 0; k < bc; k++) begin
            i = (start + k) % bc;
            if (i != excl && batch_has_req(bs, dv, i)) return i;
        end
        return -1;
    endfunction

    task automatic model_lock(input int inst, input int bs, input logic [3:0] dv, input int nb);
        m_active[inst] = 1'b1;
        m_cur[inst]    = nb;
        m_done[inst]   = 4'b0;
        for (int b = 0; b < bs; b++) m_done[inst][b] = ~dv[nb*bs + b];
    endtask

    task automatic model_cycle(input int inst, input int bs, input logic [3:0] dv,
                               input logic [3:0] eop, input logic rst,
                               output logic [EW-1:0] exp);
        logic [3:0] fin;
        logic [3:0] en;
        logic       all_fin;
        int         nxt;
        fin     = 4'b0;
        en      = 4'b0;
        all_fin = 1'b1;
        for (int b = 0; b < bs; b++) begin
            fin[b]  = m_done[inst][b] | eop[b] | ~dv[m_cur[inst]*bs + b];
            all_fin = all_fin & fin[b];
            en[b]   = m_active[inst] & ~m_done[inst][b];
        end
        exp = {1'(m_cur[inst]), m_active[inst], en, m_active[inst] & all_fin,
               m_sw[inst], m_st[inst]};

        if (rst) begin
            m_active[inst] = 1'b0;
            m_cur[inst]    = 0;
            m_rr[inst]     = 0;
            m_done[inst]   = 4'b0;
            m_sw[inst]     = '0;
            m_st[inst]     = '0;
            return;
        end
        if (!m_active[inst] && dv != 4'b0) m_st[inst] = m_st[inst] + 1;
        if (m_active[inst]) begin
            if (all_fin) begin
                m_sw[inst] = m_sw[inst] + 1;
                m_rr[inst] = (m_cur[inst] + 1) % (4 / bs);
                nxt = find_req(bs, dv, m_rr[inst], m_cur[inst]);
                if (nxt >= 0) model_lock(inst, bs, dv, nxt);
                else m_active[inst] = 1'b0;
            end else begin
                m_done[inst] = m_done[inst] | fin;
            end
        end else begin
            nxt = find_req(bs, dv, m_rr[inst], -1);
            if (nxt >= 0) model_lock(inst, bs, dv, nxt);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic [3:0] a_dv, input logic [1:0] a_eop,
                       input logic [3:0] b_dv, input logic [3:0] b_eop, input logic rst);
        logic [EW-1:0] ea, eb;
        @(posedge clk);
        #1;
        dv_a  = a_dv;
        eop_a = a_eop;
        dv_b  = b_dv;
        eop_b = b_eop;
        reset = rst;
        model_cycle(0, 2, a_dv, {2'b0, a_eop}, rst, ea);
        model_cycle(1, 4, b_dv, b_eop, rst, eb);
        if (!rst) begin
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            chk("a.batch_idx",     64'(idx_a),          64'(e[94]));
            chk("a.batch_active",  64'(act_a),          64'(e[93]));
            chk("a.block_enable",  64'({2'b0, en_a}),   64'(e[92:89]));
            chk("a.batch_done",    64'(done_a),         64'(e[88]));
            chk("a.perf_switches", 64'(sw_a),           64'(e[87:44]));
            chk("a.perf_stalls",   64'(st_a),           64'(e[43:0]));
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            chk("b.batch_idx",     64'(idx_b),          64'(e[94]));
            chk("b.batch_active",  64'(act_b),          64'(e[93]));
            chk("b.block_enable",  64'(en_b),           64'(e[92:89]));
            chk("b.batch_done",    64'(done_b),         64'(e[88]));
            chk("b.perf_switches", 64'(sw_b),           64'(e[87:44]));
            chk("b.perf_stalls",   64'(st_b),           64'(e[43:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rdv_a, rdv_b;
        logic [1:0] reop_a;
        logic [3:0] reop_b;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_cur[i] = 0; m_rr[i] = 0;
            m_done[i] = 4'b0; m_sw[i] = '0; m_st[i] = '0;
        end
        reset = 1'b1;
        dv_a = 4'b0; eop_a = 2'b0; dv_b = 4'b0; eop_b = 4'b0;

        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b0);
        // single valid slot in batch 1; B: back-to-back single-batch instructions
        cyc(4'b0100, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b0100, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b0100, 2'b00, 4'b1111, 4'b1111, 1'b0);
        cyc(4'b0100, 2'b01, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b0000, 2'b00, 4'b1111, 4'b1111, 1'b0);
        // all four valid, lane 0 EOP then lane 1 EOP, then switch with no bubble
        for (int c = 0; c < 10; c++) begin
            cyc(4'b1111, (c == 3) ? 2'b01 : ((c == 6) ? 2'b10 : 2'b00),
                4'b1111, (c % 3 == 2) ? 4'b1111 : 4'b0000, 1'b0);
        end
        cyc(4'b1111, 2'b11, 4'b0011, 4'b0011, 1'b0);
        // slot 0 drops and re-asserts while lane 1 is busy
        cyc(4'b1111, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b1110, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 2'b10, 4'b1111, 4'b1111, 1'b0);
        cyc(4'b1111, 2'b11, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0011, 2'b00, 4'b0000, 4'b0000, 1'b0);
        // both lanes EOP together with nothing else requested
        cyc(4'b0011, 2'b11, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b0);
        // reset while partially done, then re-request
        cyc(4'b1100, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b1100, 2'b01, 4'b1111, 4'b0001, 1'b0);
        cyc(4'b1100, 2'b00, 4'b1111, 4'b0000, 1'b1);
        cyc(4'b1111, 2'b00, 4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 2'b00, 4'b1111, 4'b0000, 1'b0);

        // randomized traffic with occasional resets
        rdv_a = 4'b1111;
        rdv_b = 4'b1111;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) rdv_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rdv_b = 4'($urandom_range(0, 15));
            for (int b = 0; b < 2; b++) reop_a[b] = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 4; b++) reop_b[b] = ($urandom_range(0, 1) == 0);
            cyc(rdv_a, reop_a, rdv_b, reop_b, ($urandom_range(0, 199) == 0));
        end
        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b0);

        @(posedge clk);
        @(posedge clk);
        chk("a.queue_drained", 64'(exp_a_q.size()), 64'd0);
        chk("b.queue_drained", 64'(exp_b_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
